// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state, per-stage
// valid bits, per-stage load enables and the architectural register address.
package pipeline_ctrl_pkg;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic {
        CTRL_IDLE    = 1'b0,
        CTRL_DISCARD = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic v_d;
        logic v_e;
        logic v_m;
        logic v_w;
    } stage_valid_t;

    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic en_d;
        logic en_e;
        logic en_m;
        logic en_w;
    } stage_en_t;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    function automatic logic src_matches(input logic use_src, input creg_addr_t src,
                                         input creg_addr_t dst);
        return use_src && (src == dst) && (dst != '0);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath (master) and the sequencing controller (slave):
// hazard/wait status flows in, enables, valid bits and counters flow out.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_ctrl_pkg::*;

    logic             i_wait;
    logic             d_wait;
    logic             ex_redirect;
    logic             ex_is_load;
    creg_addr_t       ex_dst;
    creg_addr_t       dec_rs1;
    creg_addr_t       dec_rs2;
    logic             dec_use_rs1;
    logic             dec_use_rs2;

    logic             pc_en;
    logic             pc_redirect;
    logic             en_d;
    logic             en_e;
    logic             en_m;
    logic             en_w;
    logic             v_d;
    logic             v_e;
    logic             v_m;
    logic             v_w;
    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;

    modport master (
        output i_wait, d_wait, ex_redirect, ex_is_load, ex_dst,
               dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        input  pc_en, pc_redirect, en_d, en_e, en_m, en_w,
               v_d, v_e, v_m, v_w, cnt_stall, cnt_flush
    );

    modport slave (
        input  i_wait, d_wait, ex_redirect, ex_is_load, ex_dst,
               dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        output pc_en, pc_redirect, en_d, en_e, en_m, en_w,
               v_d, v_e, v_m, v_w, cnt_stall, cnt_flush
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational load-use detector: a load in E whose result a valid D
// instruction needs one cycle too early.
module pipeline_ctrl_hazard_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic       v_d,
    input  logic       v_e,
    input  logic       ex_is_load,
    input  creg_addr_t ex_dst,
    input  creg_addr_t dec_rs1,
    input  creg_addr_t dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    output logic       lu
);

    assign lu = v_d && v_e && ex_is_load &&
                (src_matches(dec_use_rs1, dec_rs1, ex_dst) ||
                 src_matches(dec_use_rs2, dec_rs2, ex_dst));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: owns the inter-stage valid bits, derives load
// enables / PC control, and drops a fetch that was in flight across a redirect.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_ctrl_if.slave       bus
);

    ctrl_state_t      state_q, state_d, state_cur;
    stage_valid_t     valid_q, valid_d, valid_cur;
    stage_en_t        en;
    logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
    logic             mem_stall, redir, lu_raw, lu, fetch_ok;

    // While reset is high the outputs reflect the reset image, not stale flops
    assign valid_cur = reset ? stage_valid_t'('0) : valid_q;
    assign state_cur = reset ? CTRL_IDLE : state_q;

    pipeline_ctrl_hazard_unit u_hazard (
        .v_d         (valid_cur.v_d),
        .v_e         (valid_cur.v_e),
        .ex_is_load  (bus.ex_is_load),
        .ex_dst      (bus.ex_dst),
        .dec_rs1     (bus.dec_rs1),
        .dec_rs2     (bus.dec_rs2),
        .dec_use_rs1 (bus.dec_use_rs1),
        .dec_use_rs2 (bus.dec_use_rs2),
        .lu          (lu_raw)
    );

    assign mem_stall = valid_cur.v_m && bus.d_wait;
    assign redir     = valid_cur.v_e && bus.ex_redirect && !mem_stall;
    assign lu        = lu_raw && !mem_stall && !redir;
    assign fetch_ok  = !bus.i_wait && (state_cur == CTRL_IDLE);

    always_comb begin
        valid_d     = valid_cur;
        state_d     = state_cur;
        en          = '0;
        cnt_stall_d = cnt_stall_q;
        cnt_flush_d = cnt_flush_q;

        if (mem_stall) begin
            en.en_w       = 1'b1;
            valid_d.v_w   = 1'b0;
        end else if (redir) begin
            en            = '1;
            valid_d.v_d   = 1'b0;
            valid_d.v_e   = 1'b0;
            valid_d.v_m   = 1'b1;
            valid_d.v_w   = valid_cur.v_m;
        end else if (lu) begin
            en.en_e       = 1'b1;
            en.en_m       = 1'b1;
            en.en_w       = 1'b1;
            valid_d.v_e   = 1'b0;
            valid_d.v_m   = valid_cur.v_e;
            valid_d.v_w   = valid_cur.v_m;
        end else begin
            en.en_d       = 1'b1;
            en.en_e       = 1'b1;
            en.en_m       = 1'b1;
            en.en_w       = 1'b1;
            en.pc_en      = fetch_ok;
            valid_d.v_d   = fetch_ok;
            valid_d.v_e   = valid_cur.v_d;
            valid_d.v_m   = valid_cur.v_e;
            valid_d.v_w   = valid_cur.v_m;
        end

        // A redirect while a stale fetch may still be outstanding keeps discarding
        if (redir && (bus.i_wait || state_cur == CTRL_DISCARD)) begin
            state_d = CTRL_DISCARD;
        end else if (state_cur == CTRL_DISCARD && !bus.i_wait) begin
            state_d = CTRL_IDLE;
        end

        if (!en.pc_en) begin
            cnt_stall_d = cnt_stall_q + CNT_W'(1);
        end
        if (redir) begin
            cnt_flush_d = cnt_flush_q + CNT_W'(1);
        end

        if (reset) begin
            en = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CTRL_IDLE;
            valid_q     <= '0;
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cnt_stall_q <= cnt_stall_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign bus.pc_en       = en.pc_en;
    assign bus.pc_redirect = en.pc_redirect;
    assign bus.en_d        = en.en_d;
    assign bus.en_e        = en.en_e;
    assign bus.en_m        = en.en_m;
    assign bus.en_w        = en.en_w;
    assign bus.v_d         = valid_cur.v_d;
    assign bus.v_e         = valid_cur.v_e;
    assign bus.v_m         = valid_cur.v_m;
    assign bus.v_w         = valid_cur.v_w;
    assign bus.cnt_stall   = reset ? '0 : cnt_stall_q;
    assign bus.cnt_flush   = reset ? '0 : cnt_flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scenarios followed by random traffic, each cycle compared against a
// stage-array model of the pipeline sequencing rules.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    // Model: stage[0..3] = D, E, M, W occupancy; discarding = stale fetch pending
    bit          stage [4] = '{0, 0, 0, 0};
    bit          discarding = 0;
    logic [31:0] stallCount = '0;
    logic [31:0] flushCount = '0;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit iw, input bit dw, input bit exr,
                                 input bit ld, input logic [4:0] dst, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input bit u1, input bit u2);
        bit       memStall, redirect, hazard, fetch;
        bit       next [4];
        logic [5:0] expEn;
        @(negedge clk);
        reset           = rst;
        bus.i_wait      = iw;
        bus.d_wait      = dw;
        bus.ex_redirect = exr;
        bus.ex_is_load  = ld;
        bus.ex_dst      = dst;
        bus.dec_rs1     = rs1;
        bus.dec_rs2     = rs2;
        bus.dec_use_rs1 = u1;
        bus.dec_use_rs2 = u2;
        #1;
        if (rst) begin
            checkOutput("rst_enables", {bus.pc_en, bus.pc_redirect, bus.en_d, bus.en_e, bus.en_m, bus.en_w}, 32'h0);
            checkOutput("rst_valid", {bus.v_d, bus.v_e, bus.v_m, bus.v_w}, 32'h0);
            checkOutput("rst_cnt_stall", bus.cnt_stall, 32'h0);
            checkOutput("rst_cnt_flush", bus.cnt_flush, 32'h0);
            stage      = '{0, 0, 0, 0};
            discarding = 0;
            stallCount = '0;
            flushCount = '0;
            return;
        end
        memStall = stage[2] && dw;
        redirect = stage[1] && exr && !memStall;
        hazard   = stage[0] && stage[1] && ld && dst != 0 && !memStall && !redirect &&
                   ((u1 && rs1 == dst) || (u2 && rs2 == dst));
        fetch    = !iw && !discarding;
        // expEn bit order: pc_en, pc_redirect, en_d, en_e, en_m, en_w
        if (memStall) begin
            expEn = 6'b000001;
            next  = stage;
            next[3] = 0;
        end else if (redirect) begin
            expEn = 6'b111111;
            next  = '{0, 0, 1, stage[2]};
        end else if (hazard) begin
            expEn = 6'b000111;
            next  = '{stage[0], 0, stage[1], stage[2]};
        end else begin
            expEn = {fetch, 5'b01111};
            next  = '{fetch, stage[0], stage[1], stage[2]};
        end
        checkOutput("enables", {bus.pc_en, bus.pc_redirect, bus.en_d, bus.en_e, bus.en_m, bus.en_w}, {26'b0, expEn});
        checkOutput("valid", {bus.v_d, bus.v_e, bus.v_m, bus.v_w}, {28'b0, stage[0], stage[1], stage[2], stage[3]});
        checkOutput("cnt_stall", bus.cnt_stall, stallCount);
        checkOutput("cnt_flush", bus.cnt_flush, flushCount);
        if (!expEn[5]) stallCount++;
        if (redirect) flushCount++;
        if (redirect && (iw || discarding)) discarding = 1;
        else if (discarding && !iw) discarding = 0;
        stage = next;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        $display("[TB] pipeline_ctrl bench start");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idleCycles(5);
        checkOutput("fill_no_stall", bus.cnt_stall, 32'h0);

        // Load-use on rs1, then the same shape targeting x0
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd9, 1, 0);
        idleCycles(2);
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        idleCycles(2);

        // Data-memory wait for three cycles
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idleCycles(3);

        // Redirect with fetch ready, then redirect into DISCARD
        applyStimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idleCycles(3);
        applyStimulus(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idleCycles(4);

        // Redirect held behind a data-memory wait
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idleCycles(3);

        // Reset while discarding
        applyStimulus(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idleCycles(3);

        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (F/D/E/M/W) that carries fetch_data_t, decode_data_t, execute_data_t and memory_data_t.
- Owns the valid bit of each inter-stage register and generates per-stage load enables, PC enable and PC redirect select.
- Resolves instruction-memory wait, data-memory wait, load-use hazards and execute-stage redirects, and discards a fetch that was in flight when a redirect occurred.
- Sits beside the datapath in the core top; the datapath registers only load when their enable is high.

Parameters:
CNT_W, 32, width of the stall/flush performance counters (wrap-around)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_wait  in  1  1 = fetch has no instruction this cycle (imem busy)
d_wait  in  1  1 = M-stage data access not complete
ex_redirect  in  1  E-stage branch/jump resolved to a non-sequential PC
ex_is_load  in  1  instruction in E is a load
ex_dst  in  5  destination register (creg_addr_t) of E instruction
dec_rs1, dec_rs2  in  5 each  source registers of D instruction
dec_use_rs1, dec_use_rs2  in  1 each  D instruction reads rs1/rs2
pc_en  out  1  PC register loads next PC
pc_redirect  out  1  next PC taken from E redirect target
en_d, en_e, en_m, en_w  out  1 each  load enable of F/D, D/E, E/M, M/W registers
v_d, v_e, v_m, v_w  out  1 each  valid bit of instruction currently in D, E, M, W
cnt_stall  out  CNT_W  cycles with pc_en=0 since reset
cnt_flush  out  CNT_W  redirects accepted since reset

Behaviour:
- Reset: v_* = 0, state = IDLE, counters = 0. In the reset cycle all outputs depend only on the reset values.
- Derived terms:
  - mem_stall = v_m & d_wait
  - redir = v_e & ex_redirect & !mem_stall
  - lu = v_d & v_e & ex_is_load & ex_dst!=0 & ((dec_use_rs1 & dec_rs1==ex_dst) | (dec_use_rs2 & dec_rs2==ex_dst))
  - fetch_ok = !i_wait & state==IDLE
- Priority: mem_stall > redir > lu > i_wait.
- mem_stall:
  - en_d/en_e/en_m = 0; v_d/v_e/v_m hold; pc_en = 0.
  - en_w = 1 and v_w <= 0 (bubble into W).
  - A pending redirect waits; E is frozen, so ex_redirect is held by the datapath.
- redir:
  - pc_en = 1, pc_redirect = 1, all en_* = 1.
  - v_d <= 0 and v_e <= 0 (wrong-path F and D squashed); v_m <= 1; v_w <= v_m.
  - cnt_flush += 1.
  - If i_wait = 1 in the redir cycle, state <= DISCARD.
- lu:
  - pc_en = 0, en_d = 0 (v_d holds).
  - en_e = 1, v_e <= 0 (bubble into E).
  - M and W advance normally.
- Otherwise, normal advance:
  - All en_* = 1; pc_en = fetch_ok.
  - v_d <= fetch_ok, v_e <= v_d, v_m <= v_e, v_w <= v_m.
- FSM states and transitions:
  - IDLE -> DISCARD on redir & i_wait.
  - DISCARD -> IDLE on the first cycle with i_wait = 0. That returned instruction is dropped (v_d <= 0, pc_en = 0 that cycle).
  - DISCARD on redir stays DISCARD; the new PC is still applied.
  - reset from any state -> IDLE.
- cnt_stall increments on every non-reset cycle with pc_en = 0; it includes mem_stall, lu, i_wait and DISCARD drop cycles. Both counters wrap modulo 2^CNT_W.
- Output timing: outputs are combinational from current state and inputs. Only v_*, state and counters are registered. No comb path from en_* back to the inputs.
- Reset mid-operation (e.g. during mem_stall or DISCARD): next cycle v_* = 0, IDLE, counters 0.

Decomposition:
- Package pipes gets:
  - enum ctrl_state_t {CTRL_IDLE, CTRL_DISCARD}
  - struct stage_valid_t {v_d, v_e, v_m, v_w}
  - struct stage_en_t {pc_en, pc_redirect, en_d, en_e, en_m, en_w}
  - creg_addr_t is reused for register ports.
- Sub-module hazard_unit: purely combinational load-use compare producing lu. Keeps the register-compare logic separately testable.

Test Plan:
- Reset 3 cycles, then i_wait=0, no hazards for 5 cycles -> v_d..v_w fill 1 per cycle; after cycle 4 all v_* = 1; pc_en = 1 every cycle; cnt_stall = 0.
- Full pipe, E load ex_dst=5, D dec_rs1=5, dec_use_rs1=1 for 1 cycle -> pc_en=0, en_d=0, next v_e=0, v_m=1; cnt_stall=1. Repeat with ex_dst=0 -> no stall.
- Full pipe, d_wait=1 with v_m=1 for 3 cycles -> en_d=en_e=en_m=pc_en=0 for 3 cycles, v_w=0 after the first edge, cnt_stall=3; on release the pipe resumes with v_w=1.
- ex_redirect=1 with v_e=1, i_wait=0 -> pc_redirect=1, next v_d=0, v_e=0, cnt_flush=1, state stays IDLE.
- ex_redirect=1 with i_wait=1, then i_wait=1 for 2 more cycles, then 0 -> state DISCARD; on the i_wait=0 cycle pc_en=0 and v_d stays 0; IDLE the next cycle, and the following fetch sets v_d=1.
- d_wait=1 and ex_redirect=1 together for 2 cycles, then d_wait=0 -> no redirect during the stall (pc_redirect=0, cnt_flush=0); redirect is taken in the cycle d_wait drops.
- Assert reset while in DISCARD -> next cycle state IDLE, all v_* = 0, both counters 0.
